// File: rtl/addsub_nbits_if.sv
// ---------------------------------------------------------------------------
// addsub_nbits_if
// Request/result bundle for the multi-cycle signed adder/subtractor.
//
// Parameters:
//   W      operand width in bits
// Signals:
//   start  request strobe, sampled on the rising clock edge
//   op     0 = A+B, 1 = A-B (sampled with start)
//   a, b   W-bit two's-complement operands (sampled with start)
//   busy   computation in progress
//   done   level, high from completion until the next accepted start
//   sum    2W-bit sign-extended result
//   ovf    result does not fit in W signed bits
// Modports:
//   master  requester side (drives start/op/a/b)
//   slave   arithmetic unit side (drives busy/done/sum/ovf)
// ---------------------------------------------------------------------------
interface addsub_nbits_if #(
  parameter int W = 4
) ();
  logic             start;
  logic             op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   sum;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, sum, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, sum, ovf
  );
endinterface

// File: rtl/addsub_nbits.sv
// ---------------------------------------------------------------------------
// addsub_nbits
// Multi-cycle signed adder/subtractor. On an accepted start the W-bit
// operands are sign-extended to OW = 2W bits (B is inverted for subtraction
// with the carry seeded to 1) and the result is produced CHUNK bits per
// cycle through a registered carry. After NCH = OW/CHUNK cycles the full
// result is published on sum and done rises.
//
// Parameters:
//   W       operand width (>= 2)
//   CHUNK   result bits per cycle, must divide 2W
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-low reset
//   bus     addsub_nbits_if slave modport (start/op/a/b in,
//           busy/done/sum/ovf out)
// Build option:
//   ADDSUB_OVF_EN  when defined, ovf flags results outside the W-bit signed
//                  range; when undefined ovf is tied low.
// ---------------------------------------------------------------------------
module addsub_nbits #(
  parameter int W     = 4,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  addsub_nbits_if.slave    bus
);

  localparam int OW  = 2 * W;
  localparam int NCH = OW / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     a_ext_q, a_ext_d;
  logic [OW-1:0]     b_ext_q, b_ext_d;
  logic              carry_q, carry_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [OW-1:0]     shadow_q, shadow_d;
  logic [OW-1:0]     sum_q, sum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_accept;
  logic              last_chunk;
  logic [CHUNK-1:0]  a_chunks [NCH];
  logic [CHUNK-1:0]  b_chunks [NCH];
  logic [CHUNK-1:0]  a_sel;
  logic [CHUNK-1:0]  b_sel;
  logic [CHUNK:0]    chunk_sum;
  logic [OW-1:0]     shadow_merge;

  // Accepted only outside CALC; a start during CALC is dropped.
  assign start_accept = bus.start && (state_q != CALC);
  assign last_chunk   = (state_q == CALC) && (idx_q == IW'(NCH - 1));

  // Slice the latched operands into chunk lanes so the current lane can be
  // picked with a plain array index.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_lanes
    assign a_chunks[gi] = a_ext_q[gi*CHUNK +: CHUNK];
    assign b_chunks[gi] = b_ext_q[gi*CHUNK +: CHUNK];
  end

  assign a_sel     = a_chunks[idx_q];
  assign b_sel     = b_chunks[idx_q];
  assign chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_q};

  // Shadow register with the current chunk dropped into its lane. On the
  // last chunk this is the complete result, so it feeds sum directly.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_merge
    assign shadow_merge[gi*CHUNK +: CHUNK] =
      (idx_q == IW'(gi)) ? chunk_sum[CHUNK-1:0] : shadow_q[gi*CHUNK +: CHUNK];
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_ext_q  <= '0;
      b_ext_q  <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_ext_q  <= a_ext_d;
      b_ext_q  <= b_ext_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_ext_d  = a_ext_q;
    b_ext_d  = b_ext_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    busy_d   = busy_q;
    done_d   = done_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_accept) begin
          a_ext_d  = {{W{bus.a[W-1]}}, bus.a};
          // Subtraction as A + ~B + 1: invert B here, seed the carry with op.
          b_ext_d  = bus.op ? ~{{W{bus.b[W-1]}}, bus.b}
                            :  {{W{bus.b[W-1]}}, bus.b};
          carry_d  = bus.op;
          idx_d    = '0;
          shadow_d = '0;
          sum_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          state_d  = CALC;
        end
      end

      CALC: begin
        shadow_d = shadow_merge;
        // Carry out of the top chunk falls off here; it is never needed.
        carry_d  = chunk_sum[CHUNK];
        idx_d    = idx_q + IW'(1);
        if (last_chunk) begin
          sum_d   = shadow_merge;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;

`ifdef ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
  logic [OW-W:0] upper_bits;

  // The result fits in W signed bits exactly when bits OW-1 .. W-1 are all
  // copies of the sign bit.
  assign upper_bits = shadow_merge[OW-1:W-1];

  always_comb begin
    ovf_d = ovf_q;
    if (start_accept) begin
      ovf_d = 1'b0;
    end else if (last_chunk) begin
      ovf_d = !(&upper_bits) && (|upper_bits);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_nbits.sv
// ---------------------------------------------------------------------------
// tb_addsub_nbits
// Scoreboard bench for addsub_nbits (W=4, CHUNK=2). Each accepted start
// pushes its expected {sum, ovf} into a queue; a monitor pops and compares
// on every rising edge of done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_addsub_nbits;

  localparam int W     = 4;
  localparam int CHUNK = 2;
  localparam int OW    = 2 * W;

  logic clk;
  logic rst;

  addsub_nbits_if #(.W(W)) bus_if ();

  addsub_nbits #(.W(W), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [OW:0] exp_q [$];   // {sum, ovf}
  logic        prev_done;
  int          done_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic eff_ovf(input logic v);
`ifdef ADDSUB_OVF_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model for the random phase.
  function automatic logic [OW:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic op);
    logic signed [OW-1:0] sa, sb, r;
    logic                 o;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    r  = op ? (sa - sb) : (sa + sb);
    o  = (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1);
    return {r, eff_ovf(o)};
  endfunction

  // Monitor: compare against the scoreboard on each rising edge of done.
  always @(negedge clk) begin
    if (!rst) begin
      prev_done <= 1'b0;
    end else begin
      prev_done <= bus_if.done;
      if (bus_if.done && !prev_done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          logic [OW:0] e;
          e = exp_q.pop_front();
          check("sum", 64'(bus_if.sum), 64'(e[OW:1]));
          check("ovf", 64'(bus_if.ovf), 64'(e[0]));
          check("busy_at_done", 64'(bus_if.busy), 64'(0));
        end
      end
    end
  end

  // Wait for an idle unit, issue one start, return 1ns after the accepting edge.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                          input logic [OW-1:0] esum, input logic eovf);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_if.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.busy) check("idle_timeout", 64'(1), 64'(0));
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.op    = op;
    bus_if.start = 1'b1;
    exp_q.push_back({esum, eff_ovf(eovf)});
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.a     = W'($urandom);
    bus_if.b     = W'($urandom);
    bus_if.op    = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus_if.done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus_if.done) check("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop;
    logic [OW:0]  m;
    int           gap;
    int           n;
    int           base_seen;

    done_seen    = 0;
    prev_done    = 1'b0;
    rst          = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op    = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus_if.busy), 64'(0));
    check("rst_done", 64'(bus_if.done), 64'(0));
    check("rst_sum",  64'(bus_if.sum),  64'(0));
    check("rst_ovf",  64'(bus_if.ovf),  64'(0));
    @(negedge clk);
    rst = 1'b1;

    // 3 + 4 with cycle-accurate busy/done timing.
    do_start(4'h3, 4'h4, 1'b0, 8'h07, 1'b0);
    check("busy_k",   64'(bus_if.busy), 64'(1));
    check("done_k",   64'(bus_if.done), 64'(0));
    check("sum_busy", 64'(bus_if.sum),  64'(0));
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("busy_mid", 64'(bus_if.busy), 64'(1));
      check("done_mid", 64'(bus_if.done), 64'(0));
    end
    @(posedge clk);
    #1;
    check("done_k4", 64'(bus_if.done), 64'(1));
    check("busy_k4", 64'(bus_if.busy), 64'(0));
    check("sum_k4",  64'(bus_if.sum),  64'(8'h07));
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 64'(bus_if.done), 64'(1));
    check("sum_hold",  64'(bus_if.sum),  64'(8'h07));

    // Overflow vectors.
    do_start(4'h8, 4'h8, 1'b0, 8'hF0, 1'b1);
    wait_done();
    do_start(4'h5, 4'hD, 1'b1, 8'h08, 1'b1);
    wait_done();
    do_start(4'h8, 4'h1, 1'b1, 8'hF7, 1'b1);
    wait_done();

    // Start during CALC is ignored; start in DONE is accepted.
    do_start(4'h2, 4'h1, 1'b0, 8'h03, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus_if.a     = 4'h7;
    bus_if.b     = 4'h7;
    bus_if.op    = 1'b0;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("ign_done", 64'(bus_if.done), 64'(1));
    check("ign_sum",  64'(bus_if.sum),  64'(8'h03));
    do_start(4'h7, 4'h7, 1'b0, 8'h0E, 1'b1);
    check("redo_done_drop", 64'(bus_if.done), 64'(0));
    check("redo_busy",      64'(bus_if.busy), 64'(1));
    wait_done();

    // Reset aborts an operation in flight.
    do_start(4'h1, 4'h1, 1'b0, 8'h02, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 64'(bus_if.busy), 64'(0));
    check("abort_done", 64'(bus_if.done), 64'(0));
    check("abort_sum",  64'(bus_if.sum),  64'(0));
    check("abort_ovf",  64'(bus_if.ovf),  64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base_seen = done_seen;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done",  64'(done_seen - base_seen), 64'(0));
    check("abort_idle_busy", 64'(bus_if.busy), 64'(0));
    do_start(4'hF, 4'hF, 1'b0, 8'hFE, 1'b0);
    wait_done();

    // Random operations with random spacing, including back-to-back.
    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 1'($urandom);
      m   = model(ra, rb, rop);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      do_start(ra, rb, rop, m[OW:1], m[0]);
    end
    wait_done();

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
